// File: rtl/ode_mem_map_pkg.sv
// Solver RAM memory-map offsets, size limits and loader state encoding.
// The CHK state exists only in builds with LOAD_CHECKSUM_EN defined.
package ode_mem_map_pkg;

    localparam int MAX_DIM = 50;
    localparam int MAX_T   = 16;
    localparam int CNT_W   = 12;

    localparam int N_P4   = 51;
    localparam int N_P1   = 900;
    localparam int M_P1   = 901;
    localparam int H_P4   = 50;
    localparam int ERR_P4 = 52;
    localparam int T_P4   = 53;
    localparam int T_P1   = 902;
    localparam int U_P1   = 50;

    typedef enum logic [3:0] {
        IDLE, HDR_N, HDR_M, HDR_H, HDR_ERR, HDR_K,
        LD_T, LD_A, LD_B, LD_X, LD_U0, LD_U,
        DONE, ERR
`ifdef LOAD_CHECKSUM_EN
        , CHK
`endif
    } load_state_t;

    function automatic logic in_range(input logic [7:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/ram_load_counter.sv
// Section word index: clears to zero, steps on each accepted word,
// flags the terminal count when the index equals the section's last index.
module ram_load_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/ram_stream_loader.sv
// Streams header/matrices/vectors into the four-port solver RAM; writes land one cycle after each handshake,
// no RAM-side back-pressure, in_ready only while loading. LOAD_CHECKSUM_EN adds a trailing XOR check word.
module ram_stream_loader
    import ode_mem_map_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDRESS_WIDTH_1 = 10,
    parameter int ADDRESS_WIDTH_2 = 12,
    parameter int ADDRESS_WIDTH_3 = 12,
    parameter int ADDRESS_WIDTH_4 = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ADDRESS_WIDTH_1-1:0] address_1,
    output logic [ADDRESS_WIDTH_2-1:0] address_2,
    output logic [ADDRESS_WIDTH_3-1:0] address_3,
    output logic [ADDRESS_WIDTH_4-1:0] address_4,
    output logic [DATA_WIDTH-1:0]      data_write_1,
    output logic [DATA_WIDTH-1:0]      data_write_2,
    output logic [DATA_WIDTH-1:0]      data_write_3,
    output logic [DATA_WIDTH-1:0]      data_write_4,
    output logic                       WR_signal_1,
    output logic                       WR_signal_2,
    output logic                       WR_signal_3,
    output logic                       WR_signal_4,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

`ifdef LOAD_CHECKSUM_EN
    localparam load_state_t END_ST = CHK;
`else
    localparam load_state_t END_ST = DONE;
`endif

    load_state_t state_q, state_d;
    logic [5:0] n_q, n_d, m_q, m_d;
    logic [4:0] k_q, k_d;
    logic       err_q, err_d, done_q, done_d;
    logic [ADDRESS_WIDTH_1-1:0] addr1_q, addr1_d;
    logic [ADDRESS_WIDTH_2-1:0] addr2_q, addr2_d;
    logic [ADDRESS_WIDTH_3-1:0] addr3_q, addr3_d;
    logic [ADDRESS_WIDTH_4-1:0] addr4_q, addr4_d;
    logic [DATA_WIDTH-1:0] dat1_q, dat1_d, dat2_q, dat2_d, dat3_q, dat3_d, dat4_q, dat4_d;
    logic wr1_q, wr1_d, wr2_q, wr2_d, wr3_q, wr3_d, wr4_q, wr4_d;

    logic             active, in_ld, accept, start_ok, idx_tc;
    logic [CNT_W-1:0] idx, last_idx, n_w, m_w, k_w;

    assign in_ld = state_q inside {LD_T, LD_A, LD_B, LD_X, LD_U0, LD_U};

    always_comb begin
        active = in_ld || (state_q inside {HDR_N, HDR_M, HDR_H, HDR_ERR, HDR_K});
`ifdef LOAD_CHECKSUM_EN
        if (state_q == CHK) active = 1'b1;
`endif
    end

    assign accept   = in_valid && active;
    assign start_ok = start && (state_q inside {IDLE, DONE, ERR});
    assign n_w      = CNT_W'(n_q);
    assign m_w      = CNT_W'(m_q);
    assign k_w      = CNT_W'(k_q);

    // Section lengths are at least 1 whenever the section is entered.
    always_comb begin
        last_idx = '0;
        case (state_q)
            LD_T:    last_idx = k_w - CNT_W'(1);
            LD_A:    last_idx = n_w * n_w - CNT_W'(1);
            LD_B:    last_idx = n_w * m_w - CNT_W'(1);
            LD_X:    last_idx = n_w - CNT_W'(1);
            LD_U0:   last_idx = m_w - CNT_W'(1);
            LD_U:    last_idx = k_w * m_w - CNT_W'(1);
            default: last_idx = '0;
        endcase
    end

    ram_load_counter #(.W(CNT_W)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_ld || (accept && idx_tc)),
        .en_i   (accept),
        .last_i (last_idx),
        .cnt_o  (idx),
        .tc_o   (idx_tc)
    );

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (accept)   sum_q <= sum_q ^ in_data;
    end
`endif

    always_comb begin
        state_d = state_q;
        n_d = n_q; m_d = m_q; k_d = k_q;
        err_d = err_q;
        addr1_d = addr1_q; addr2_d = addr2_q; addr3_d = addr3_q; addr4_d = addr4_q;
        dat1_d = dat1_q; dat2_d = dat2_q; dat3_d = dat3_q; dat4_d = dat4_q;
        wr1_d = 1'b0; wr2_d = 1'b0; wr3_d = 1'b0; wr4_d = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: if (start_ok) begin state_d = HDR_N; err_d = 1'b0; end
            HDR_N: if (accept) begin
                if (in_range(in_data[7:0], 1, MAX_DIM)) begin
                    n_d = in_data[5:0]; state_d = HDR_M;
                    wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(N_P1); dat1_d = in_data;
                    wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(N_P4); dat4_d = in_data;
                end else begin state_d = ERR; err_d = 1'b1; end
            end
            HDR_M: if (accept) begin
                if (in_range(in_data[7:0], 0, MAX_DIM)) begin
                    m_d = in_data[5:0]; state_d = HDR_H;
                    wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(M_P1); dat1_d = in_data;
                end else begin state_d = ERR; err_d = 1'b1; end
            end
            HDR_H: if (accept) begin
                state_d = HDR_ERR;
                wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(H_P4); dat4_d = in_data;
            end
            HDR_ERR: if (accept) begin
                state_d = HDR_K;
                wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(ERR_P4); dat4_d = in_data;
            end
            HDR_K: if (accept) begin
                if (in_range(in_data[7:0], 1, MAX_T)) begin k_d = in_data[4:0]; state_d = LD_T; end
                else begin state_d = ERR; err_d = 1'b1; end
            end
            LD_T: if (accept) begin
                wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(T_P1) + ADDRESS_WIDTH_1'(idx); dat1_d = in_data;
                wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(T_P4) + ADDRESS_WIDTH_4'(idx); dat4_d = in_data;
                if (idx_tc) state_d = LD_A;
            end
            LD_A: if (accept) begin
                wr2_d = 1'b1; addr2_d = ADDRESS_WIDTH_2'(idx); dat2_d = in_data;
                if (idx_tc) state_d = (m_q == '0) ? LD_X : LD_B;
            end
            LD_B: if (accept) begin
                wr3_d = 1'b1; addr3_d = ADDRESS_WIDTH_3'(idx); dat3_d = in_data;
                if (idx_tc) state_d = LD_X;
            end
            LD_X: if (accept) begin
                wr4_d = 1'b1; addr4_d = ADDRESS_WIDTH_4'(idx); dat4_d = in_data;
                if (idx_tc) state_d = (m_q == '0) ? END_ST : LD_U0;
            end
            LD_U0: if (accept) begin
                wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(idx); dat1_d = in_data;
                if (idx_tc) state_d = LD_U;
            end
            LD_U: if (accept) begin
                wr1_d = 1'b1; addr1_d = ADDRESS_WIDTH_1'(U_P1) + ADDRESS_WIDTH_1'(idx); dat1_d = in_data;
                if (idx_tc) state_d = END_ST;
            end
`ifdef LOAD_CHECKSUM_EN
            CHK: if (accept) begin
                if (in_data == sum_q) state_d = DONE;
                else begin state_d = ERR; err_d = 1'b1; end
            end
`endif
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q <= '0; m_q <= '0; k_q <= '0;
            err_q <= 1'b0; done_q <= 1'b0;
            addr1_q <= '0; addr2_q <= '0; addr3_q <= '0; addr4_q <= '0;
            dat1_q <= '0; dat2_q <= '0; dat3_q <= '0; dat4_q <= '0;
            wr1_q <= 1'b0; wr2_q <= 1'b0; wr3_q <= 1'b0; wr4_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d; m_q <= m_d; k_q <= k_d;
            err_q <= err_d; done_q <= done_d;
            addr1_q <= addr1_d; addr2_q <= addr2_d; addr3_q <= addr3_d; addr4_q <= addr4_d;
            dat1_q <= dat1_d; dat2_q <= dat2_d; dat3_q <= dat3_d; dat4_q <= dat4_d;
            wr1_q <= wr1_d; wr2_q <= wr2_d; wr3_q <= wr3_d; wr4_q <= wr4_d;
        end
    end

    assign in_ready     = active;
    assign busy         = active;
    assign done         = done_q;
    assign err          = err_q;
    assign address_1    = addr1_q;
    assign address_2    = addr2_q;
    assign address_3    = addr3_q;
    assign address_4    = addr4_q;
    assign data_write_1 = dat1_q;
    assign data_write_2 = dat2_q;
    assign data_write_3 = dat3_q;
    assign data_write_4 = dat4_q;
    assign WR_signal_1  = wr1_q;
    assign WR_signal_2  = wr2_q;
    assign WR_signal_3  = wr3_q;
    assign WR_signal_4  = wr4_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Random-stream bench for ram_stream_loader: a memory-map model builds each stream and
// the exact write sequence it must produce, including error and reset cases.
module tb_ram_stream_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, busy, done, err;
    logic [9:0]  address_1;
    logic [11:0] address_2, address_3;
    logic [6:0]  address_4;
    logic [63:0] data_write_1, data_write_2, data_write_3, data_write_4;
    logic        WR_signal_1, WR_signal_2, WR_signal_3, WR_signal_4;

    ram_stream_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .address_1(address_1), .address_2(address_2), .address_3(address_3), .address_4(address_4),
        .data_write_1(data_write_1), .data_write_2(data_write_2),
        .data_write_3(data_write_3), .data_write_4(data_write_4),
        .WR_signal_1(WR_signal_1), .WR_signal_2(WR_signal_2),
        .WR_signal_3(WR_signal_3), .WR_signal_4(WR_signal_4),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int port; int addr; logic [63:0] data; int cyc; } wr_t;
    typedef struct { int widx; int port; int addr; logic [63:0] data; } exp_t;

    wr_t         mon_q[$];
    exp_t        exp_q[$];
    logic [63:0] stream_q[$];
    int          hs_q[$];
    int          done_q[$];
    bit          expect_err;
    int          gap_mode;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(negedge clk) begin
        if (WR_signal_1) mon_q.push_back('{1, int'(address_1), data_write_1, cyc});
        if (WR_signal_2) mon_q.push_back('{2, int'(address_2), data_write_2, cyc});
        if (WR_signal_3) mon_q.push_back('{3, int'(address_3), data_write_3, cyc});
        if (WR_signal_4) mon_q.push_back('{4, int'(address_4), data_write_4, cyc});
        if (done) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic void add_word(input logic [63:0] d, input int pa, input int aa,
                                     input int pb, input int ab);
        int w;
        w = stream_q.size();
        stream_q.push_back(d);
        if (pa != 0) exp_q.push_back('{w, pa, aa, d});
        if (pb != 0) exp_q.push_back('{w, pb, ab, d});
    endfunction

    function automatic void reject_last();
        while (exp_q.size() > 0 && exp_q[$].widx == stream_q.size() - 1) void'(exp_q.pop_back());
        expect_err = 1'b1;
    endfunction

    // Stream image plus the RAM writes it must cause, straight from the memory map.
    function automatic void build(input int n, input int m, input int k);
        stream_q.delete(); exp_q.delete(); expect_err = 1'b0;
        add_word(64'(n), 1, 900, 4, 51);
        if (n < 1 || n > 50) begin reject_last(); return; end
        add_word(64'(m), 1, 901, 0, 0);
        if (m > 50) begin reject_last(); return; end
        add_word(rnd64(), 4, 50, 0, 0);
        add_word(rnd64(), 4, 52, 0, 0);
        add_word(64'(k), 0, 0, 0, 0);
        if (k < 1 || k > 16) begin reject_last(); return; end
        for (int i = 0; i < k; i++)     add_word(rnd64(), 1, 902 + i, 4, 53 + i);
        for (int i = 0; i < n * n; i++) add_word(rnd64(), 2, i, 0, 0);
        for (int i = 0; i < n * m; i++) add_word(rnd64(), 3, i, 0, 0);
        for (int i = 0; i < n; i++)     add_word(rnd64(), 4, i, 0, 0);
        for (int i = 0; i < m; i++)     add_word(rnd64(), 1, i, 0, 0);
        for (int i = 0; i < k * m; i++) add_word(rnd64(), 1, 50 + i, 0, 0);
`ifdef LOAD_CHECKSUM_EN
        begin
            logic [63:0] x;
            x = '0;
            foreach (stream_q[i]) x = x ^ stream_q[i];
            add_word(x, 0, 0, 0, 0);
        end
`endif
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send();
        hs_q.delete();
        for (int j = 0; j < stream_q.size(); j++) begin
            int g;
            int t;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin @(negedge clk); in_valid = 1'b0; end
            @(negedge clk); in_valid = 1'b1; in_data = stream_q[j];
            t = 0;
            while (!in_ready && t < 20) begin @(negedge clk); t++; end
            if (!in_ready) begin
                check("ready_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                return;
            end
            hs_q.push_back(cyc);
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic compare(input string name);
        int lim;
        check({name, ":wr_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        lim = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            int ec;
            ec = (exp_q[i].widx < hs_q.size()) ? hs_q[exp_q[i].widx] + 1 : -1;
            check({name, ":wr_port_addr_cyc"},
                  {16'(mon_q[i].port), 16'(mon_q[i].addr), 32'(mon_q[i].cyc)},
                  {16'(exp_q[i].port), 16'(exp_q[i].addr), 32'(ec)});
            check({name, ":wr_data"}, mon_q[i].data, exp_q[i].data);
        end
        if (!expect_err) begin
            check({name, ":done_pulses"}, 64'(done_q.size()), 64'(1));
            if (done_q.size() > 0 && hs_q.size() > 0)
                check({name, ":done_cycle"}, 64'(done_q[0]), 64'(hs_q[$] + 1));
            check({name, ":err"}, 64'(err), 64'(0));
            check({name, ":busy"}, 64'(busy), 64'(0));
        end else begin
            check({name, ":done_pulses"}, 64'(done_q.size()), 64'(0));
            check({name, ":err"}, 64'(err), 64'(1));
            check({name, ":in_ready"}, 64'(in_ready), 64'(0));
        end
    endtask

    task automatic run_case(input string name, input int n, input int m, input int k,
                            input int gm, input bit use_start);
        mon_q.delete(); done_q.delete();
        gap_mode = gm;
        build(n, m, k);
        if (use_start) do_start();
        send();
        repeat (4) @(negedge clk);
        compare(name);
    endtask

    function automatic int port_writes(input int p);
        int c;
        c = 0;
        foreach (mon_q[i]) if (mon_q[i].port == p) c++;
        return c;
    endfunction

    function automatic logic any_output();
        return |{address_1, address_2, address_3, address_4,
                 data_write_1, data_write_2, data_write_3, data_write_4,
                 WR_signal_1, WR_signal_2, WR_signal_3, WR_signal_4,
                 busy, done, err, in_ready};
    endfunction

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset:outputs", 64'(any_output()), 64'(0));
        rst = 1'b0;

        run_case("basic", 2, 1, 2, 0, 1'b1);
        check("basic:port2_writes", 64'(port_writes(2)), 64'(4));
        check("basic:port3_writes", 64'(port_writes(3)), 64'(2));

        run_case("gapA", 3, 2, 1, 1, 1'b1);
        check("gapA:port2_writes", 64'(port_writes(2)), 64'(9));

        run_case("n0", 0, 1, 1, 0, 1'b1);
        do_start();
        check("recover:err", 64'(err), 64'(0));
        check("recover:in_ready", 64'(in_ready), 64'(1));

        run_case("m0", 1, 0, 1, 0, 1'b0);
        check("m0:port3_writes", 64'(port_writes(3)), 64'(0));

        run_case("m51", 2, 51, 1, 0, 1'b1);
        run_case("k17", 2, 3, 17, 0, 1'b1);
        run_case("k0", 1, 1, 0, 0, 1'b1);
        run_case("n51", 51, 1, 1, 0, 1'b1);

        for (int r = 0; r < 4; r++)
            run_case("rand", int'($urandom_range(1, 6)), int'($urandom_range(0, 5)),
                     int'($urandom_range(1, 4)), 2, 1'b1);

        run_case("max", 50, 50, 16, 0, 1'b1);

`ifdef LOAD_CHECKSUM_EN
        mon_q.delete(); done_q.delete(); gap_mode = 0;
        build(2, 1, 1);
        stream_q[stream_q.size() - 1] = stream_q[stream_q.size() - 1] ^ 64'h1;
        expect_err = 1'b1;
        do_start();
        send();
        repeat (4) @(negedge clk);
        compare("chkflip");
`endif

        // Abort after the first B word.
        mon_q.delete(); done_q.delete(); gap_mode = 0;
        build(2, 2, 1);
        while (stream_q.size() > 11) void'(stream_q.pop_back());
        do_start();
        send();
        check("midload:busy", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1 check("midload:async_clear", 64'(any_output()), 64'(0));
        @(negedge clk); rst = 1'b0;
        mon_q.delete();
        in_valid = 1'b1; in_data = rnd64();
        repeat (5) @(negedge clk);
        check("postrst:in_ready", 64'(in_ready), 64'(0));
        check("postrst:writes", 64'(mon_q.size()), 64'(0));
        in_valid = 1'b0;
        do_start();
        check("postrst:restart", 64'(in_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
